// File: rtl/axis_boxcar_decimator.sv
// axis_boxcar_decimator: averages blocks of 2^L valid samples, holds the mean and strobes decii_clk once per block.
// Define AXIS_BOXCAR_ROUNDING_EN for round-half-up of the mean; otherwise the mean truncates toward -inf.
module axis_boxcar_decimator #(
    parameter int signal_width          = 32,
    parameter int max_log2_decimation   = 16,
    parameter int configuration_address = 1000
) (
    input  logic                    aclk,
    input  logic                    resetn,
    input  logic [31:0]             config_addr,
    input  logic [511:0]            config_data,
    input  logic [signal_width-1:0] S_AXIS_in_tdata,
    input  logic                    S_AXIS_in_tvalid,
    output logic [signal_width-1:0] M_AXIS_out_tdata,
    output logic                    M_AXIS_out_tvalid,
    output logic                    decii_clk,
    output logic [signal_width-1:0] M_AXIS_pass_tdata,
    output logic                    M_AXIS_pass_tvalid
);
    localparam int aw = signal_width + max_log2_decimation;
    localparam int lw = $clog2(max_log2_decimation + 1);
    localparam int cw = max_log2_decimation + 1;
    localparam logic [1:0] st_disabled = 2'd0;
    localparam logic [1:0] st_accum    = 2'd1;
    localparam logic [1:0] st_dump     = 2'd2;
    localparam logic [cw-1:0] cnt_one = 1;

    logic [1:0]           state;
    logic [lw-1:0]        l;
    logic [aw-1:0]        acc;
    logic [cw-1:0]        cnt;
    logic signed [aw-1:0] total;
    logic                 pend;
    logic                 cfg_hit;
    logic [lw-1:0]        cfg_l;
    logic [aw-1:0]        sample;
    logic [aw-1:0]        bias;
    logic [cw-1:0]        last_cnt;
    logic signed [aw-1:0] mean;
    logic                 unused;

    assign cfg_hit  = config_addr == 32'(configuration_address);
    assign cfg_l    = config_data[31:0] > 32'(max_log2_decimation) ? lw'(max_log2_decimation) : config_data[lw-1:0];
    assign sample   = {{max_log2_decimation{S_AXIS_in_tdata[signal_width-1]}}, S_AXIS_in_tdata};
    assign last_cnt = (cnt_one << l) - cnt_one;
`ifdef AXIS_BOXCAR_ROUNDING_EN
    assign bias = l == '0 ? '0 : {{(aw-1){1'b0}}, 1'b1} << (l - lw'(1));
`else
    assign bias = '0;
`endif
    assign mean   = total >>> l;
    assign unused = ^{config_data[511:33], mean[aw-1:signal_width]};

    assign decii_clk          = M_AXIS_out_tvalid;
    assign M_AXIS_pass_tdata  = S_AXIS_in_tdata;
    assign M_AXIS_pass_tvalid = S_AXIS_in_tvalid;

    // Config writes restart the block and cancel any pending strobe; otherwise run accumulate/dump and the output stage.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state             <= st_disabled;
            l                 <= '0;
            acc               <= '0;
            cnt               <= '0;
            total             <= '0;
            pend              <= 1'b0;
            M_AXIS_out_tdata  <= '0;
            M_AXIS_out_tvalid <= 1'b0;
        end else if (cfg_hit) begin
            state             <= config_data[32] ? st_accum : st_disabled;
            l                 <= cfg_l;
            acc               <= '0;
            cnt               <= '0;
            pend              <= 1'b0;
            M_AXIS_out_tvalid <= 1'b0;
        end else begin
            pend              <= state == st_dump;
            M_AXIS_out_tvalid <= pend;
            if (pend)
                M_AXIS_out_tdata <= mean[signal_width-1:0];
            if (state == st_dump) begin
                total <= acc + bias;
                acc   <= S_AXIS_in_tvalid ? sample : '0;
                cnt   <= S_AXIS_in_tvalid ? cnt_one : '0;
                state <= st_accum;
            end else if (state == st_accum && S_AXIS_in_tvalid) begin
                acc <= acc + sample;
                cnt <= cnt + cnt_one;
                if (cnt == last_cnt)
                    state <= st_dump;
            end
        end
    end
endmodule
